// File: rtl/pulse_sync_pkg.sv
// Shared types and defaults for the request/acknowledge pulse synchronizer.
package pulse_sync_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int STAGES_DEF = 2;
  localparam int CNT_W_DEF  = 4;

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop level synchronizer for a single asynchronous bit.
module cdc_sync #(
  parameter int pSTAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [pSTAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[pSTAGES-2:0], d};
  end

  assign q = ff[pSTAGES-1];

endmodule

// File: rtl/pulse_sync_tx.sv
// Sending half of a toggle handshake pulse synchronizer with a pending-event counter.
// Define PULSE_SYNC_TX_OVF_EN to compile in the ovf (dropped event) pulse.
module pulse_sync_tx
  import pulse_sync_pkg::*;
#(
  parameter int pSTAGES = STAGES_DEF,
  parameter int pCNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pls_in,
  input  logic              ack_tgl,
  output logic              req_tgl,
  output logic              busy,
  output logic [pCNT_W-1:0] pend_cnt,
  output logic              ovf
);

  localparam logic [pCNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nx;
  logic   ack_s, done, pend_nz, full;
  logic   issue, inc, dec, sat;

  cdc_sync #(.pSTAGES(pSTAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_tgl),
    .q     (ack_s)
  );

  assign done    = (ack_s == req_tgl);
  assign pend_nz = |pend_cnt;
  assign full    = (pend_cnt == CNT_MAX);

  // inc: pls_in goes into the counter; dec: a counted event is issued.
  // A pulse on an issuing cycle with an empty counter is consumed directly.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    dec      = 1'b0;
    inc      = pls_in;
    case (state)
      IDLE: begin
        inc = pls_in & pend_nz;
        if (pls_in || pend_nz) begin
          issue    = 1'b1;
          dec      = pend_nz;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (done) begin
          if (pend_nz || pls_in) begin
            issue = 1'b1;
            dec   = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sat = inc & ~dec & full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_tgl  <= 1'b0;
      pend_cnt <= '0;
    end else begin
      state <= state_nx;
      if (issue) req_tgl <= ~req_tgl;
      if (inc && !dec && !full)  pend_cnt <= pend_cnt + 1'b1;
      else if (dec && !inc)      pend_cnt <= pend_cnt - 1'b1;
    end
  end

`ifdef PULSE_SYNC_TX_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else        ovf <= sat;
  end
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state == WAIT) | pend_nz;

endmodule
